// File: rtl/radix_alu_queued_pkg.sv
// Shared definitions for the queued multi-radix ALU: opcode map, op classes,
// FSM state encoding and opcode helper functions.
package radix_alu_queued_pkg;

    typedef enum logic [3:0] {
        OP_BIN_ADD   = 4'd0,
        OP_BIN_SUB   = 4'd1,
        OP_BIN_MUL   = 4'd2,
        OP_DEC_ADD   = 4'd3,
        OP_DEC_SUB   = 4'd4,
        OP_DEC_MUL10 = 4'd5,
        OP_DUO_ADD12 = 4'd6,
        OP_DUO_SUB12 = 4'd7,
        OP_DUO_MUL3  = 4'd8
    } opcode_e;

    // Class codes double as the NATIVE_RADIX selector values.
    typedef enum logic [1:0] {
        OPC_BIN = 2'd0,
        OPC_DEC = 2'd1,
        OPC_DUO = 2'd2,
        OPC_ILL = 2'd3
    } op_class_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic op_class_e op_class(input logic [3:0] op);
        op_class_e cls;
        case (op)
            OP_BIN_ADD, OP_BIN_SUB, OP_BIN_MUL:     cls = OPC_BIN;
            OP_DEC_ADD, OP_DEC_SUB, OP_DEC_MUL10:   cls = OPC_DEC;
            OP_DUO_ADD12, OP_DUO_SUB12, OP_DUO_MUL3: cls = OPC_DUO;
            default:                                cls = OPC_ILL;
        endcase
        return cls;
    endfunction

    function automatic logic op_is_legal(input logic [3:0] op);
        return op_class(op) != OPC_ILL;
    endfunction

endpackage

// File: rtl/radix_alu_queued_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued ALU commands.
// Read data always shows the head entry; pop and push are ignored when
// empty / full respectively.
module radix_alu_fifo #(
    parameter int unsigned DATA_W = 40,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              do_wr, do_rd;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/radix_alu_queued.sv
// Queued multi-radix ALU: commands enter a FIFO, execute one at a time with
// class-dependent latency, and the result is held until the consumer takes it.
// Optional build macro RADIX_ALU_PERF_EN adds perf_ops/perf_stall counters.
module radix_alu_queued
    import radix_alu_queued_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned TAG_W        = 4,
    parameter int unsigned NATIVE_RADIX = 1,
    parameter int unsigned LAT_FAST     = 1,
    parameter int unsigned LAT_EMU      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_opcode,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err,
    output logic                 busy
`ifdef RADIX_ALU_PERF_EN
   ,output logic [31:0]          perf_ops,
    output logic [31:0]          perf_stall
`endif
);

    localparam int unsigned RW      = 2 * WIDTH;
    localparam int unsigned PW      = 4 + 2 * WIDTH + TAG_W;
    localparam int unsigned LAT_F   = (LAT_FAST == 0) ? 1 : LAT_FAST;
    localparam int unsigned LAT_E   = (LAT_EMU == 0) ? 1 : LAT_EMU;
    localparam int unsigned LAT_MAX = (LAT_F > LAT_E) ? LAT_F : LAT_E;
    localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

    // ---------------- command FIFO ----------------
    logic          fifo_full, fifo_empty, fifo_pop;
    logic [PW-1:0] fifo_wdata, fifo_rdata;

    logic [3:0]       head_op;
    logic [WIDTH-1:0] head_a, head_b;
    logic [TAG_W-1:0] head_tag;

    assign fifo_wdata = {in_tag, in_b, in_a, in_opcode};
    assign head_op    = fifo_rdata[3:0];
    assign head_a     = fifo_rdata[4 +: WIDTH];
    assign head_b     = fifo_rdata[4 + WIDTH +: WIDTH];
    assign head_tag   = fifo_rdata[4 + 2*WIDTH +: TAG_W];

    radix_alu_fifo #(
        .DATA_W (PW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (in_valid),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign in_ready = !fifo_full;

    // ---------------- state ----------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [RW-1:0]    res_q, res_d;
    logic [TAG_W-1:0] otag_q, otag_d;
    logic             err_q, err_d;

    op_class_e        head_cls;
    logic [CNT_W-1:0] lat_sel;
    logic [RW-1:0]    alu_res;
    logic [RW-1:0]    a_ext, b_ext;

    // Latency of the command at the FIFO head, chosen by its op class.
    always_comb begin
        head_cls = op_class(head_op);
        if (head_cls == OPC_ILL)
            lat_sel = CNT_W'(1);
        else if (32'(head_cls) == NATIVE_RADIX)
            lat_sel = CNT_W'(LAT_F);
        else
            lat_sel = CNT_W'(LAT_E);
    end

    // Result datapath on zero-extended operands of the in-flight command.
    always_comb begin
        a_ext = RW'(a_q);
        b_ext = RW'(b_q);
        case (op_q)
            OP_BIN_ADD, OP_DEC_ADD, OP_DUO_ADD12: alu_res = a_ext + b_ext;
            OP_BIN_SUB, OP_DEC_SUB, OP_DUO_SUB12: alu_res = a_ext - b_ext;
            OP_BIN_MUL:   alu_res = a_ext * b_ext;
            OP_DEC_MUL10: alu_res = (a_ext << 3) + (a_ext << 1);
            OP_DUO_MUL3:  alu_res = (a_ext << 1) + a_ext;
            default:      alu_res = '0;
        endcase
    end

    // FSM next-state: pop into EXEC from IDLE or straight from a completed HOLD.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        tag_d    = tag_q;
        res_d    = res_q;
        otag_d   = otag_q;
        err_d    = err_q;
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) fifo_pop = 1'b1;
            end
            ST_EXEC: begin
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    res_d   = alu_res;
                    otag_d  = tag_q;
                    err_d   = !op_is_legal(op_q);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (!fifo_empty) fifo_pop = 1'b1;
                    else             state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fifo_pop) begin
            op_d    = head_op;
            a_d     = head_a;
            b_d     = head_b;
            tag_d   = head_tag;
            cnt_d   = lat_sel;
            state_d = ST_EXEC;
        end
    end

    // FSM and datapath registers; reset drops the in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            res_q   <= '0;
            otag_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            otag_q  <= otag_d;
            err_q   <= err_d;
        end
    end

    assign out_valid  = (state_q == ST_HOLD);
    assign out_result = res_q;
    assign out_tag    = otag_q;
    assign out_err    = err_q;
    assign busy       = !fifo_empty || (state_q != ST_IDLE);

`ifdef RADIX_ALU_PERF_EN
    logic [31:0] perf_ops_q, perf_stall_q;

    // Handshake and back-pressure counters, free-running and wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (out_valid && out_ready)  perf_ops_q   <= perf_ops_q + 32'd1;
            if (out_valid && !out_ready) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_radix_alu_queued.sv
// Self-checking bench for radix_alu_queued with NATIVE_RADIX=1 (DEC fast).
module tb_radix_alu_queued;

    localparam int unsigned W   = 16;
    localparam int unsigned TW  = 4;
    localparam int unsigned NAT = 1;
    localparam int unsigned LF  = 1;
    localparam int unsigned LE  = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_opcode;
    logic [W-1:0]  in_a, in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] out_result;
    logic [TW-1:0] out_tag;
    logic          out_err;
    logic          busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
    } cmd_t;

    cmd_t q[$];

    radix_alu_queued #(
        .WIDTH        (W),
        .DEPTH        (4),
        .TAG_W        (TW),
        .NATIVE_RADIX (NAT),
        .LAT_FAST     (LF),
        .LAT_EMU      (LE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference: opcodes 0-2 binary, 3-5 decimal, 6-8 duodecimal; rest illegal.
    function automatic logic [31:0] m_res(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint r;
        case (op)
            4'd0, 4'd3, 4'd6: r = ua + ub;
            4'd1, 4'd4, 4'd7: begin
                r = ua - ub;
                if (r < 0) r = r + 64'd4294967296;
            end
            4'd2:    r = ua * ub;
            4'd5:    r = ua * 10;
            4'd8:    r = ua * 3;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    function automatic logic m_err(input logic [3:0] op);
        return op > 4'd8;
    endfunction

    function automatic int m_lat(input logic [3:0] op);
        if (op > 4'd8) return 1;
        return (int'(op) / 3 == NAT) ? LF : LE;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag);
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        tick();
        in_valid  = 1'b0;
    endtask

    // One command through an empty, idle unit with out_ready=1.
    task automatic single(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [TW-1:0] tag, output logic [31:0] res);
        int n = 0;
        push(op, a, b, tag);
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({nm, "_lat"}, 64'(n), 64'(1 + m_lat(op)));
        chk({nm, "_res"}, 64'(out_result), 64'(m_res(op, a, b)));
        chk({nm, "_tag"}, 64'(out_tag), 64'(tag));
        chk({nm, "_err"}, 64'(out_err), 64'(m_err(op)));
        res = out_result;
        tick();
        chk({nm, "_drop"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] hres;
        logic [TW-1:0] htag;
        logic herr, hold_prev;
        cmd_t c;
        int n;

        rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready",  64'(in_ready),   64'(1));
        chk("rst_out_valid", 64'(out_valid),  64'(0));
        chk("rst_result",    64'(out_result), 64'(0));
        chk("rst_tag",       64'(out_tag),    64'(0));
        chk("rst_err",       64'(out_err),    64'(0));
        chk("rst_busy",      64'(busy),       64'(0));
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // Native and emulated latency, arithmetic corner values.
        single("dec_add", 4'd3, 16'd123, 16'd877, 4'd3, r);
        chk("dec_add_lit", 64'(r), 64'(1000));
        single("bin_mul", 4'd2, 16'hFFFF, 16'hFFFF, 4'd1, r);
        chk("bin_mul_lit", 64'(r), 64'h0000_0000_FFFE_0001);
        single("bin_sub", 4'd1, 16'd5, 16'd7, 4'd2, r);
        chk("bin_sub_lit", 64'(r), 64'h0000_0000_FFFF_FFFE);
        single("duo_mul3", 4'd8, 16'd4, 16'd99, 4'd5, r);
        chk("duo_mul3_lit", 64'(r), 64'(12));
        single("dec_mul10", 4'd5, 16'd6553, 16'd0, 4'd6, r);
        chk("dec_mul10_lit", 64'(r), 64'(65530));

        // Illegal opcode, then a normal op behind it.
        single("illegal", 4'hF, 16'd9, 16'd9, 4'd7, r);
        single("after_ill", 4'd0, 16'd2, 16'd2, 4'd8, r);
        chk("after_ill_lit", 64'(r), 64'(4));

        // Back-pressure: 4 queued plus 1 in flight, then drain in order.
        out_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            c.op  = 4'($urandom_range(0, 8));
            c.a   = 16'($urandom);
            c.b   = 16'($urandom);
            c.tag = 4'(t);
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            chk("bp_ready_wait", 64'(n), 64'(0));
            q.push_back(c);
            push(c.op, c.a, c.b, c.tag);
        end
        chk("bp_full", 64'(in_ready), 64'(0));
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("bp_valid", 64'(out_valid), 64'(1));
        hres = out_result; htag = out_tag; herr = out_err;
        repeat (3) tick();
        chk("bp_hold_valid", 64'(out_valid), 64'(1));
        chk("bp_hold_res", 64'(out_result), 64'(hres));
        chk("bp_hold_tag", 64'(out_tag), 64'(htag));
        chk("bp_hold_err", 64'(out_err), 64'(herr));
        chk("bp_still_full", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            if (out_valid) begin
                c = q.pop_front();
                chk("bp_order_tag", 64'(out_tag), 64'(c.tag));
                chk("bp_order_res", 64'(out_result), 64'(m_res(c.op, c.a, c.b)));
            end
            tick();
            n++;
        end
        chk("bp_drained", 64'(q.size()), 64'(0));

        // Random traffic with random back-pressure against the queue model.
        hold_prev = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            in_valid  = ($urandom_range(0, 1) == 1);
            in_opcode = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (hold_prev) begin
                chk("rnd_hold_valid", 64'(out_valid), 64'(1));
                chk("rnd_hold_res", 64'(out_result), 64'(hres));
                chk("rnd_hold_tag", 64'(out_tag), 64'(htag));
            end
            if (in_valid && in_ready) begin
                c.op = in_opcode; c.a = in_a; c.b = in_b; c.tag = in_tag;
                q.push_back(c);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", 64'(1), 64'(0));
                end else begin
                    c = q.pop_front();
                    chk("rnd_res", 64'(out_result), 64'(m_res(c.op, c.a, c.b)));
                    chk("rnd_tag", 64'(out_tag), 64'(c.tag));
                    chk("rnd_err", 64'(out_err), 64'(m_err(c.op)));
                end
            end
            hold_prev = out_valid && !out_ready;
            hres = out_result; htag = out_tag;
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        n = 0;
        while ((q.size() != 0 || busy) && n < 500) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("drain_spurious", 64'(1), 64'(0));
                end else begin
                    c = q.pop_front();
                    chk("drain_res", 64'(out_result), 64'(m_res(c.op, c.a, c.b)));
                    chk("drain_tag", 64'(out_tag), 64'(c.tag));
                end
            end
            tick();
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'(0));
        chk("drain_idle", 64'(busy), 64'(0));

        // Reset during EXEC with two commands still queued.
        out_ready = 1'b0;
        push(4'd2, 16'd3, 16'd4, 4'd1);
        push(4'd2, 16'd5, 16'd6, 4'd2);
        push(4'd2, 16'd7, 16'd8, 4'd3);
        rst = 1'b1;
        tick();
        chk("mrst_valid", 64'(out_valid), 64'(0));
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_ready", 64'(in_ready), 64'(1));
        rst = 1'b0;
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) n++;
        end
        chk("mrst_no_stale", 64'(n), 64'(0));
        chk("mrst_idle", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
